bmp_frame_write_ctrl: RTL and testbench

//  Sequences one frame of pixel pairs from an upstream processing stage into the
//  BMP image writer. Buffers pairs in a small FIFO, accepts them through a

---
 rtl/bmp_frame_write_ctrl_if.sv | 28 ++
 rtl/bmp_frame_write_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_bmp_frame_write_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_frame_write_ctrl_if.sv
// Pixel-pair bus between the upstream stage, the frame write controller and the BMP writer.
interface bmp_frame_write_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        HSYNC;
    logic [7:0]  DATA_WRITE_R0;
    logic [7:0]  DATA_WRITE_G0;
    logic [7:0]  DATA_WRITE_B0;
    logic [7:0]  DATA_WRITE_R1;
    logic [7:0]  DATA_WRITE_G1;
    logic [7:0]  DATA_WRITE_B1;
    logic        write_done;

    modport slave (
        input  in_valid, in_data, write_done,
        output in_ready, HSYNC,
        output DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        output DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1
    );

    modport master (
        output in_valid, in_data, write_done,
        input  in_ready, HSYNC,
        input  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        input  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1
    );
endinterface

// File: rtl/bmp_frame_write_ctrl.sv
// Frame write controller: buffers upstream pixel pairs and streams exactly one frame
// of them to the BMP writer with optional per-row HSYNC blanking.
module bmp_frame_write_ctrl #(
    parameter int WIDTH      = 10,
    parameter int HEIGHT     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_GAP    = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    bmp_frame_write_ctrl_if.slave bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [18:0]           pair_count
);
    localparam int TOTAL     = (WIDTH * HEIGHT) / 2;
    localparam int ROW_PAIRS = WIDTH / 2;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int COLW      = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1;
    localparam int GW        = $clog2(ROW_GAP + 1) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        GAP     = 3'd2,
        WAIT_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state_r, state_n_s;
    logic [47:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, count_n_s;
    logic [18:0]     acc_r, acc_n_s, pair_count_r, pair_n_s;
    logic [COLW-1:0] col_r, col_n_s;
    logic [GW-1:0]   gap_r, gap_n_s;
    logic            push_s, pop_s, clear_s, row_end_s, last_s, ready_n_s;
    logic            in_ready_r, hsync_r, busy_r, frame_done_r;
    logic [47:0]     data_r;

    // Next-state decode: pops only in STREAM, row/frame boundaries steer the FSM.
    always_comb begin
        state_n_s = state_r;
        pop_s     = 1'b0;
        clear_s   = 1'b0;
        push_s    = bus.in_valid & in_ready_r;
        row_end_s = (col_r == COLW'(ROW_PAIRS - 1));
        last_s    = (pair_count_r == 19'(TOTAL - 1));
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n_s = STREAM;
                    clear_s   = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            STREAM: begin
                if (count_r != CW'(0)) begin
                    pop_s = 1'b1;
                    if (last_s) begin
                        state_n_s = WAIT_WR;
                    end else if (row_end_s && (ROW_GAP > 0)) begin
                        state_n_s = GAP;
                    end else begin
                        state_n_s = STREAM;
                    end
                end else begin
                    state_n_s = STREAM;
                end
            end
            GAP: begin
                if (gap_r == GW'(ROW_GAP - 1)) begin
                    state_n_s = STREAM;
                end else begin
                    state_n_s = GAP;
                end
            end
            WAIT_WR: begin
                if (bus.write_done) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = WAIT_WR;
                end
            end
            DONE:    state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // Next counter values; in_ready is derived from these so it never sees a same-cycle pop.
    always_comb begin
        count_n_s = count_r;
        acc_n_s   = acc_r;
        pair_n_s  = pair_count_r;
        col_n_s   = col_r;
        gap_n_s   = GW'(0);
        if (clear_s) begin
            count_n_s = CW'(0);
            acc_n_s   = 19'd0;
            pair_n_s  = 19'd0;
            col_n_s   = COLW'(0);
            gap_n_s   = GW'(0);
        end else begin
            if (push_s && !pop_s) begin
                count_n_s = count_r + CW'(1);
            end else if (!push_s && pop_s) begin
                count_n_s = count_r - CW'(1);
            end else begin
                count_n_s = count_r;
            end
            if (push_s) begin
                acc_n_s = acc_r + 19'd1;
            end else begin
                acc_n_s = acc_r;
            end
            if (pop_s) begin
                pair_n_s = pair_count_r + 19'd1;
                col_n_s  = row_end_s ? COLW'(0) : col_r + COLW'(1);
            end else begin
                pair_n_s = pair_count_r;
                col_n_s  = col_r;
            end
            if (state_r == GAP) begin
                gap_n_s = gap_r + GW'(1);
            end else begin
                gap_n_s = GW'(0);
            end
        end
        ready_n_s = ((state_n_s == STREAM) || (state_n_s == GAP)) &&
                    (count_n_s < CW'(FIFO_DEPTH)) && (acc_n_s < 19'(TOTAL));
    end

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Counters, pointers and registered writer-side outputs.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            wr_ptr_r     <= AW'(0);
            rd_ptr_r     <= AW'(0);
            count_r      <= CW'(0);
            acc_r        <= 19'd0;
            pair_count_r <= 19'd0;
            col_r        <= COLW'(0);
            gap_r        <= GW'(0);
            in_ready_r   <= 1'b0;
            hsync_r      <= 1'b0;
            data_r       <= 48'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (clear_s) begin
                wr_ptr_r <= AW'(0);
                rd_ptr_r <= AW'(0);
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
                if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (pop_s) data_r <= mem_r[rd_ptr_r];
            count_r      <= count_n_s;
            acc_r        <= acc_n_s;
            pair_count_r <= pair_n_s;
            col_r        <= col_n_s;
            gap_r        <= gap_n_s;
            in_ready_r   <= ready_n_s;
            hsync_r      <= pop_s;
            busy_r       <= (state_n_s == STREAM) || (state_n_s == GAP) || (state_n_s == WAIT_WR);
            frame_done_r <= (state_n_s == DONE);
        end
    end

    // FIFO storage; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge HCLK) begin
        if (push_s) mem_r[wr_ptr_r] <= bus.in_data;
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.HSYNC         = hsync_r;
    assign bus.DATA_WRITE_R0 = data_r[47:40];
    assign bus.DATA_WRITE_G0 = data_r[39:32];
    assign bus.DATA_WRITE_B0 = data_r[31:24];
    assign bus.DATA_WRITE_R1 = data_r[23:16];
    assign bus.DATA_WRITE_G1 = data_r[15:8];
    assign bus.DATA_WRITE_B1 = data_r[7:0];
    assign busy              = busy_r;
    assign frame_done        = frame_done_r;
    assign pair_count        = pair_count_r;
endmodule

// File: tb/tb_bmp_frame_write_ctrl.sv
// Randomized bench for bmp_frame_write_ctrl against a queue-based frame model.
module tb_bmp_frame_write_ctrl;
    localparam int WIDTH      = 4;
    localparam int HEIGHT     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ROW_GAP    = 6;
    localparam int TOTAL      = WIDTH * HEIGHT / 2;
    localparam int ROW_PAIRS  = WIDTH / 2;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        start = 1'b0;
    logic        busy, frame_done;
    logic [18:0] pair_count;

    bmp_frame_write_ctrl_if bus();

    bmp_frame_write_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(FIFO_DEPTH), .ROW_GAP(ROW_GAP)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done), .pair_count(pair_count)
    );

    always #5 HCLK = ~HCLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of one frame, expressed as a pair queue and phase of the frame.
    typedef enum int {PH_IDLE, PH_RUN, PH_GAP, PH_WAIT, PH_DONE} ph_t;
    ph_t         m_phase;
    logic [47:0] m_q[$];
    int          m_acc, m_issued, m_gap_left;
    logic        m_ready, m_hsync, m_busy, m_done;
    logic [47:0] m_data;

    task automatic model_reset();
        m_phase = PH_IDLE; m_q.delete(); m_acc = 0; m_issued = 0; m_gap_left = 0;
        m_ready = 1'b0; m_hsync = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_data = 48'd0;
    endtask

    task automatic model_edge();
        bit push, pop;
        if (!HRESET) begin
            model_reset();
            return;
        end
        push = bus.in_valid && m_ready;
        pop  = (m_phase == PH_RUN) && (m_q.size() > 0);
        m_hsync = pop;
        if (pop) begin
            m_data = m_q.pop_front();
            m_issued++;
        end
        case (m_phase)
            PH_IDLE: if (start) begin
                m_phase = PH_RUN; m_q.delete(); m_acc = 0; m_issued = 0;
            end
            PH_RUN: if (pop) begin
                if (m_issued == TOTAL) m_phase = PH_WAIT;
                else if ((m_issued % ROW_PAIRS) == 0 && ROW_GAP > 0) begin
                    m_phase = PH_GAP; m_gap_left = ROW_GAP;
                end
            end
            PH_GAP: begin
                m_gap_left--;
                if (m_gap_left == 0) m_phase = PH_RUN;
            end
            PH_WAIT: if (bus.write_done) m_phase = PH_DONE;
            default: m_phase = PH_IDLE;
        endcase
        if (push) begin
            m_q.push_back(bus.in_data);
            m_acc++;
        end
        m_ready = (m_phase == PH_RUN || m_phase == PH_GAP) && (m_q.size() < FIFO_DEPTH) && (m_acc < TOTAL);
        m_busy  = (m_phase == PH_RUN || m_phase == PH_GAP || m_phase == PH_WAIT);
        m_done  = (m_phase == PH_DONE);
    endtask

    function automatic logic [70:0] obs();
        return {bus.in_ready, bus.HSYNC, busy, frame_done, pair_count,
                bus.DATA_WRITE_R0, bus.DATA_WRITE_G0, bus.DATA_WRITE_B0,
                bus.DATA_WRITE_R1, bus.DATA_WRITE_G1, bus.DATA_WRITE_B1};
    endfunction

    function automatic logic [70:0] expv();
        return {m_ready, m_hsync, m_busy, m_done, 19'(m_issued), m_data};
    endfunction

    task automatic drive_cycle(input logic st, input logic vl, input logic wd);
        start          = st;
        bus.in_valid   = vl;
        bus.in_data    = {16'($urandom()), $urandom()};
        bus.write_done = wd;
        model_edge();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 48'd0; bus.write_done = 1'b0;
        HRESET = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        model_reset();
        vectors++;
        if (obs() !== 71'd0) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", obs(), 71'd0);
        end
        HRESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b1);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_stream_gap();
        int hs = 0;
        drive_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            hs += int'(bus.HSYNC);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL stream_gap cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
        vectors++;
        if (hs !== TOTAL || bus.in_ready !== 1'b0 || busy !== 1'b1 || pair_count !== 19'(TOTAL)) begin
            miscompares++;
            $display("FAIL stream_gap_end: got hs=%0d rdy=%b busy=%b pc=%0d expected hs=%0d rdy=0 busy=1 pc=%0d",
                     hs, bus.in_ready, busy, pair_count, TOTAL, TOTAL);
        end
    endtask

    task automatic test_done_restart();
        drive_cycle(1'b0, 1'b0, 1'b1);
        vectors++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b busy=%b (%h) expected done=1 busy=0 (%h)",
                     frame_done, busy, obs(), expv());
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1);
            vectors++;
            if (frame_done !== 1'b0 || obs() !== expv()) begin
                miscompares++;
                $display("FAIL done_after cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0);
        vectors++;
        if (pair_count !== 19'd0 || busy !== 1'b1 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL restart: got pc=%0d busy=%b expected pc=0 busy=1", pair_count, busy);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 70; i++) begin
            drive_cycle(1'b0, (i % 2) == 0, 1'b0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL toggle cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, i == 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL toggle_end cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_ignored();
        drive_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            drive_cycle($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                        (m_phase != PH_WAIT) && ($urandom_range(0, 2) == 0));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL ignored cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(i < 2, 1'b0, i == 2);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL ignored_end cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            int dly = $urandom_range(0, 3);
            int pct = $urandom_range(30, 90);
            drive_cycle(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 300 && m_phase != PH_WAIT; i++) begin
                drive_cycle(1'b0, $urandom_range(0, 99) < pct, 1'b0);
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL random f%0d cycle %0d: got %h expected %h", f, i, obs(), expv());
                end
            end
            for (int i = 0; i < dly + 3; i++) begin
                drive_cycle(1'b0, 1'b1, i == dly);
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL random_end f%0d cycle %0d: got %h expected %h", f, i, obs(), expv());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        drive_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !hit; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            hit = (m_phase == PH_GAP) && (m_q.size() == 3);
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reset_mid_setup: got no gap with 3 queued pairs expected one within 40 cycles");
        end
        start = 1'b0; bus.in_valid = 1'b0; bus.write_done = 1'b0;
        HRESET = 1'b0;
        #2;
        model_reset();
        vectors++;
        if (obs() !== 71'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h expected %h", obs(), 71'd0);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        HRESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b1);
            vectors++;
            if (obs() !== expv() || frame_done !== 1'b0 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_after cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream_gap();
        test_done_restart();
        test_toggle();
        test_ignored();
        test_random_frames();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
